// File: rtl/irq_exc_controller_if.sv
// Control-flow handshake bundle between the PC-update datapath and the irq/exception sequencer.
// Latency: pure wiring, no storage.
// Backpressure: none; the controller answers every cycle.
interface irq_exc_controller_if #(
    parameter int CNT_W = 16
);
    // datapath -> controller
    logic             irq_req;
    logic             irq_en;
    logic             undef_instr;
    logic             eret;
    logic [31:0]      pc_cur;
    logic [31:0]      pc_next;
    // controller -> datapath
    logic             pc_override;
    logic [31:0]      pc_vector;
    logic             kill_wb;
    logic             epc_we;
    logic [31:0]      epc_wdata;
    logic [31:0]      epc;
    logic             kernel;
    logic             irq_ack;
    logic             exc_nested;
    logic [CNT_W-1:0] irq_count;

    modport master (
        output irq_req, irq_en, undef_instr, eret, pc_cur, pc_next,
        input  pc_override, pc_vector, kill_wb, epc_we, epc_wdata, epc,
               kernel, irq_ack, exc_nested, irq_count
    );

    modport slave (
        input  irq_req, irq_en, undef_instr, eret, pc_cur, pc_next,
        output pc_override, pc_vector, kill_wb, epc_we, epc_wdata, epc,
               kernel, irq_ack, exc_nested, irq_count
    );
endinterface

// File: rtl/irq_exc_controller.sv
// Chooses next-PC source (normal/irq vector/exc vector), owns EPC, kernel mode and re-entry holdoff.
// Latency: vector/kill/EPC-write decisions are combinational in the same cycle; state updates on the edge.
// Backpressure: none; interrupts wait in a pending latch until enabled, in user mode and past holdoff.
module irq_exc_controller #(
    parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
    parameter logic [31:0] EXC_VECTOR = 32'h80000008,
    parameter int unsigned HOLDOFF    = 1,
    parameter int          CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    irq_exc_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        USER  = 2'd0,
        K_IRQ = 2'd1,
        K_EXC = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pending_q;
    logic             irq_prev_q;
    logic [3:0]       holdoff_q;
    logic [31:0]      epc_q;
    logic [CNT_W-1:0] irq_count_q;
    logic             exc_nested_q;

    logic             take_exc;
    logic             take_irq;
    logic             leave_kernel;
    logic             nest_set;
    logic             irq_edge;

    // A fresh timer event is a 0->1 transition; a held level must not re-arm pending.
    assign irq_edge = bus.irq_req & ~irq_prev_q;

    // Next-state and per-cycle control decisions; everything is quiet while reset is high.
    always_comb begin
        state_d          = state_q;
        take_exc         = 1'b0;
        take_irq         = 1'b0;
        leave_kernel     = 1'b0;
        nest_set         = 1'b0;
        bus.pc_override  = 1'b0;
        bus.pc_vector    = 32'h0;
        bus.kill_wb      = 1'b0;
        bus.epc_we       = 1'b0;
        bus.epc_wdata    = 32'h0;
        bus.irq_ack      = 1'b0;
        if (!reset) begin
            unique case (state_q)
                USER: begin
                    // Exceptions win; a pending interrupt stays latched for later.
                    if (bus.undef_instr) begin
                        take_exc = 1'b1;
                    end else if (pending_q && bus.irq_en && (holdoff_q == 4'd0)) begin
                        take_irq = 1'b1;
                    end
                end
                default: begin
                    // Handlers are not re-entered: a bad opcode is killed and flagged only.
                    if (bus.undef_instr) begin
                        nest_set    = 1'b1;
                        bus.kill_wb = 1'b1;
                    end else if (bus.eret) begin
                        leave_kernel = 1'b1;
                        state_d      = USER;
                    end
                end
            endcase

            if (take_exc) begin
                state_d         = K_EXC;
                bus.pc_override = 1'b1;
                bus.pc_vector   = EXC_VECTOR;
                bus.kill_wb     = 1'b1;
                bus.epc_we      = 1'b1;
                bus.epc_wdata   = bus.pc_cur;
            end else if (take_irq) begin
                // Current instruction retires, so resume at its successor (keeps branch targets).
                state_d         = K_IRQ;
                bus.pc_override = 1'b1;
                bus.pc_vector   = IRQ_VECTOR;
                bus.epc_we      = 1'b1;
                bus.epc_wdata   = bus.pc_next;
                bus.irq_ack     = 1'b1;
            end
        end
    end

    // State register plus pending latch, holdoff, EPC, counter and nested-exception flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= USER;
            pending_q    <= 1'b0;
            irq_prev_q   <= 1'b0;
            holdoff_q    <= 4'd0;
            epc_q        <= 32'h0;
            irq_count_q  <= '0;
            exc_nested_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= bus.irq_req;

            if (take_irq) begin
                pending_q <= 1'b0;
            end else if (irq_edge) begin
                pending_q <= 1'b1;
            end

            if (leave_kernel) begin
                holdoff_q <= 4'(HOLDOFF);
            end else if ((state_q == USER) && (holdoff_q != 4'd0)) begin
                holdoff_q <= holdoff_q - 4'd1;
            end

            if (bus.epc_we) begin
                epc_q <= bus.epc_wdata;
            end

            if (take_irq && (irq_count_q != {CNT_W{1'b1}})) begin
                irq_count_q <= irq_count_q + 1'b1;
            end

            if (nest_set) begin
                exc_nested_q <= 1'b1;
            end
        end
    end

    assign bus.kernel     = !reset && (state_q != USER);
    assign bus.epc        = epc_q;
    assign bus.irq_count  = irq_count_q;
    assign bus.exc_nested = exc_nested_q;

endmodule

// File: doc/irq_exc_controller.md
Name: irq_exc_controller

Overview:
- Sequences control flow for the single-cycle MIPS core on timer interrupts, undefined-instruction exceptions and kernel return (jr $26).
- Sits beside the PC-update logic. It decides each cycle whether the next PC is the datapath's normal next PC, the interrupt vector or the exception vector.
- Owns the EPC register that the datapath writes into $26, and tracks kernel mode.
- Rate-limits re-entry so user code always makes forward progress between interrupts.

Parameters:
- IRQ_VECTOR, 32'h80000004, next PC when an interrupt is taken.
- EXC_VECTOR, 32'h80000008, next PC when an exception is taken.
- HOLDOFF, 1, number of user-mode instructions that must retire after a return before the next interrupt may be taken (range 0..15).
- CNT_W, 16, width of the interrupt-taken counter.

Ports:
- clk  in  1  system clock; one instruction retires per rising edge.
- reset  in  1  synchronous, active-high.
- irq_req  in  1  timer interrupt level (TCON status from the timer).
- irq_en  in  1  global interrupt enable.
- undef_instr  in  1  decoder flag: current instruction is undefined.
- eret  in  1  decoder flag: current instruction is jr $26.
- pc_cur  in  32  PC of the current instruction.
- pc_next  in  32  datapath-computed next PC (PC+4, branch or jump target).
- pc_override  out  1  when high, the PC register loads pc_vector instead of pc_next.
- pc_vector  out  32  IRQ_VECTOR or EXC_VECTOR.
- kill_wb  out  1  suppresses register-file and memory writes of the current instruction.
- epc_we  out  1  write-enable for $26 this edge; data is epc_wdata.
- epc_wdata  out  32  return address for $26.
- epc  out  32  registered copy of the last saved return address.
- kernel  out  1  high while in an ISR or exception handler.
- irq_ack  out  1  one-cycle pulse on the edge an interrupt is taken; clears the timer's status.
- exc_nested  out  1  sticky: an undefined instruction executed in kernel mode.
- irq_count  out  CNT_W  number of interrupts taken, saturating.

Behaviour:
- Reset values: state USER, pending 0, holdoff counter 0, epc 0, irq_count 0, exc_nested 0.
- All combinational outputs evaluate to 0 when the reset input is high.
- States: USER, K_IRQ, K_EXC. kernel = (state != USER).
- Pending latch:
  - Sets on a rising edge of irq_req, detected by a registered previous sample.
  - Holds until the interrupt is taken or reset.
  - A high level on irq_req does not re-set pending after it is taken.
- Holdoff counter:
  - Loads HOLDOFF on the edge that leaves kernel.
  - Decrements once per USER cycle while nonzero.
- Take-exception condition (combinational, same cycle), in USER with undef_instr=1:
  - pc_override=1, pc_vector=EXC_VECTOR, kill_wb=1.
  - epc_we=1, epc_wdata=pc_cur.
  - Next state K_EXC.
- Take-interrupt condition, in USER with pending=1, irq_en=1, holdoff=0 and undef_instr=0:
  - pc_override=1, pc_vector=IRQ_VECTOR, kill_wb=0 (current instruction completes).
  - epc_we=1, epc_wdata=pc_next, so a branch or jump target is preserved.
  - irq_ack=1; pending cleared; irq_count incremented unless at all-ones.
  - Next state K_IRQ.
- Priority: exception over interrupt. A pending interrupt survives an exception and is evaluated again after return.
- epc register updates on every edge with epc_we=1.
- In K_IRQ or K_EXC:
  - No interrupt is taken and pending may still set.
  - undef_instr gives kill_wb=1 and sets exc_nested. No vector, no state change; PC follows pc_next.
  - eret=1 gives next state USER and holdoff loaded. The PC follows pc_next, which is the $26 target.
- eret in USER is an ordinary jr: no state change.
- eret together with undef_instr cannot occur (eret is a defined instruction); if both are high, treat as undef_instr.
- Interrupt edge in the same cycle as eret: pending sets, and the interrupt is taken after holdoff expires.
- Reset mid-handler returns to USER with all state cleared. pc_override is 0 on the reset cycle.

Test Plan:
- Timer pulse while USER, pc_cur=0x00000040, pc_next=0x00000044, irq_en=1, HOLDOFF=1:
  - -> pc_override=1, pc_vector=0x80000004, epc_wdata=0x44, irq_ack pulse, kernel=1 next cycle, irq_count=1.
- Timer edge during a taken branch, pc_next=0x0000000C:
  - -> epc=0x0000000C. jr $26 with eret=1 -> kernel=0.
  - A second edge arriving one cycle later is taken only after one USER instruction retires.
- undef_instr at pc_cur=0x00000100 while pending=1:
  - -> vector 0x80000008, kill_wb=1, epc=0x100, irq_ack=0.
  - After eret plus holdoff, the interrupt is taken.
- undef_instr while in K_IRQ:
  - -> kill_wb=1, exc_nested=1 and stays 1, pc_override=0, kernel remains 1.
- irq_en=0 with a timer edge:
  - -> no take, pending held. Raising irq_en -> taken that cycle.
- CNT_W=2, five interrupts:
  - -> irq_count saturates at 3.
  - Reset asserted mid-ISR -> kernel=0, epc=0, irq_count=0, pending=0.
